// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: command/state encodings and address field layout for the SDRAM arbiter
package sdram_arbiter_pkg;
  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10
  } cmd_t;
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ISSUE     = 2'b01,
    WAIT_DONE = 2'b10
  } state_t;
  localparam int ADDR_W   = 24;
  localparam int DATA_W   = 16;
  localparam int COL_W    = 9;
  localparam int BANK_W   = 2;
  localparam int ROW_W    = 13;
  localparam int COL_LSB  = 0;
  localparam int BANK_LSB = COL_LSB + COL_W;
  localparam int ROW_LSB  = BANK_LSB + BANK_W;
endpackage

// File: rtl/sdram_arb_pick.sv
// sdram_arb_pick: combinational request picker, round-robin or fixed priority (SDRAM_ARB_FIXED_PRIO_EN)
module sdram_arb_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               valid
);
  assign valid = |req;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign win = req & (~req + NUM_REQ'(1));
`else
  logic [2*NUM_REQ-1:0] rot;
  logic [2*NUM_REQ-1:0] hot;
  logic [NUM_REQ-1:0]   low;
  assign rot = {req, req} >> ptr;
  assign low = rot[NUM_REQ-1:0] & (~rot[NUM_REQ-1:0] + NUM_REQ'(1));
  assign hot = {{NUM_REQ{1'b0}}, low} << ptr;
  assign win = hot[NUM_REQ-1:0] | hot[2*NUM_REQ-1:NUM_REQ];
`endif
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the sdram_interface command port between NUM_REQ requesters with a timeout watchdog (SDRAM_ARB_FIXED_PRIO_EN selects fixed priority)
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      CLK_48MHZ,
  input  logic                      NSYSRESET,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ-1:0]        REQ_WR,
  input  logic [ADDR_W*NUM_REQ-1:0] REQ_ADDR,
  input  logic [DATA_W*NUM_REQ-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]        GNT,
  output logic [NUM_REQ-1:0]        ACK,
  output logic                      ERR,
  output logic [DATA_W-1:0]         RD_DATA,
  output logic [7:0]                ERR_CNT,
  output logic [BANK_W-1:0]         A_IN_BANK,
  output logic [COL_W-1:0]          A_IN_COL,
  output logic [ROW_W-1:0]          A_IN_ROW,
  output logic [DATA_W-1:0]         D_IN,
  output logic [1:0]                CMD_IN,
  input  logic [1:0]                SD_STATUS,
  input  logic [DATA_W-1:0]         DATA_READ
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;
  state_t              state, state_nx;
  cmd_t                cmd;
  logic [NUM_REQ-1:0]  win;
  logic                valid;
  logic [PTR_W-1:0]    ptr, widx, w_idx;
  logic [WD_W-1:0]     wdog;
  logic                wr_l, wr_w;
  logic [ADDR_W-1:0]   addr_w;
  logic [DATA_W-1:0]   data_w;
  logic                ready, done, start, finish, timeout, abort;
  assign ready   = SD_STATUS[0];
  assign done    = SD_STATUS[1];
  assign start   = state == IDLE && valid;
  assign finish  = state == WAIT_DONE && done;
  assign timeout = state != IDLE && wdog == WD_W'(TIMEOUT_CYC - 1);
  assign abort   = timeout && !finish;
  assign CMD_IN  = cmd;
  sdram_arb_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req  (REQ),
    .ptr  (ptr),
    .win  (win),
    .valid(valid)
  );
  // route the winning requester's slice to the latch inputs
  always_comb begin
    addr_w = '0;
    data_w = '0;
    wr_w   = 1'b0;
    w_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (win[k]) begin
        addr_w = REQ_ADDR[k*ADDR_W +: ADDR_W];
        data_w = REQ_DATA[k*DATA_W +: DATA_W];
        wr_w   = REQ_WR[k];
        w_idx  = PTR_W'(k);
      end
  end
  // next state: a completion or timeout always returns to IDLE
  always_comb begin
    state_nx = state == IDLE ? (valid ? ISSUE : IDLE)
             : (finish || abort) ? IDLE
             : (state == ISSUE && !ready) ? WAIT_DONE
             : state;
  end
  // state register
  always_ff @(posedge CLK_48MHZ or negedge NSYSRESET)
    if (!NSYSRESET) state <= IDLE;
    else state <= state_nx;
  // grant latch, command drive, watchdog and completion pulses
  always_ff @(posedge CLK_48MHZ or negedge NSYSRESET)
    if (!NSYSRESET) begin
      GNT       <= '0;
      ACK       <= '0;
      ERR       <= 1'b0;
      RD_DATA   <= '0;
      ERR_CNT   <= '0;
      A_IN_BANK <= '0;
      A_IN_COL  <= '0;
      A_IN_ROW  <= '0;
      D_IN      <= '0;
      cmd       <= CMD_NOP;
      ptr       <= '0;
      widx      <= '0;
      wdog      <= '0;
      wr_l      <= 1'b0;
    end else begin
      ACK <= '0;
      ERR <= 1'b0;
      if (state != IDLE) wdog <= wdog + 1'b1;
      if (state == ISSUE && !ready) cmd <= CMD_NOP;
      if (start) begin
        GNT       <= win;
        widx      <= w_idx;
        wr_l      <= wr_w;
        A_IN_BANK <= addr_w[BANK_LSB +: BANK_W];
        A_IN_COL  <= addr_w[COL_LSB +: COL_W];
        A_IN_ROW  <= addr_w[ROW_LSB +: ROW_W];
        D_IN      <= data_w;
        cmd       <= wr_w ? CMD_WRITE : CMD_READ;
        wdog      <= '0;
      end
      if (finish || abort) begin
        GNT <= '0;
        ACK <= GNT;
        ERR <= abort;
        cmd <= CMD_NOP;
        if (finish && !wr_l) RD_DATA <= DATA_READ;
        if (abort && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 1'b1;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        ptr <= '0;
`else
        ptr <= widx == PTR_W'(NUM_REQ - 1) ? '0 : widx + 1'b1;
`endif
      end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed self-checking bench for sdram_arbiter (NUM_REQ=3, TIMEOUT_CYC=16)
module tb_sdram_arbiter;
  localparam int N = 3;
  logic          CLK_48MHZ = 1'b0;
  logic          NSYSRESET = 1'b0;
  logic [N-1:0]  REQ = '0, REQ_WR = '0;
  logic [24*N-1:0] REQ_ADDR = '0;
  logic [16*N-1:0] REQ_DATA = '0;
  logic [N-1:0]  GNT, ACK;
  logic          ERR;
  logic [15:0]   RD_DATA, D_IN;
  logic [7:0]    ERR_CNT;
  logic [1:0]    A_IN_BANK, CMD_IN;
  logic [8:0]    A_IN_COL;
  logic [12:0]   A_IN_ROW;
  logic [1:0]    SD_STATUS = 2'b01;
  logic [15:0]   DATA_READ = '0;
  int n_chk = 0;
  int n_pass = 0;

  sdram_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut (
    .CLK_48MHZ(CLK_48MHZ), .NSYSRESET(NSYSRESET), .REQ(REQ), .REQ_WR(REQ_WR),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .GNT(GNT), .ACK(ACK), .ERR(ERR),
    .RD_DATA(RD_DATA), .ERR_CNT(ERR_CNT), .A_IN_BANK(A_IN_BANK), .A_IN_COL(A_IN_COL),
    .A_IN_ROW(A_IN_ROW), .D_IN(D_IN), .CMD_IN(CMD_IN), .SD_STATUS(SD_STATUS),
    .DATA_READ(DATA_READ)
  );

  always #5 CLK_48MHZ = ~CLK_48MHZ;

  task automatic tick;
    @(posedge CLK_48MHZ);
    #1;
  endtask

  task automatic do_reset;
    NSYSRESET = 1'b0;
    REQ = '0;
    SD_STATUS = 2'b01;
    tick;
    NSYSRESET = 1'b1;
    tick;
  endtask

  // one complete operation: grant, accept, lat wait cycles, DONE, ACK
  task automatic run_op(input logic [N-1:0] eg, input logic rd, input logic [15:0] rdat,
                        input int lat, input logic drop, input logic [N-1:0] raise, input logic keep);
    tick;
    n_chk++; if (GNT !== eg) $display("FAIL op_gnt got %b want %b", GNT, eg); else n_pass++;
    n_chk++; if (CMD_IN !== (rd ? 2'b10 : 2'b01)) $display("FAIL op_cmd got %b want %b", CMD_IN, rd ? 2'b10 : 2'b01); else n_pass++;
    REQ = (drop ? REQ & ~eg : REQ) | raise;
    SD_STATUS = 2'b00;
    tick;
    n_chk++; if (CMD_IN !== 2'b00) $display("FAIL op_nop got %b want 00", CMD_IN); else n_pass++;
    repeat (lat) tick;
    n_chk++; if (ACK !== '0 || GNT !== eg) $display("FAIL op_wait ack %b gnt %b want 000 %b", ACK, GNT, eg); else n_pass++;
    SD_STATUS = 2'b10;
    DATA_READ = rdat;
    tick;
    n_chk++; if (ACK !== eg) $display("FAIL op_ack got %b want %b", ACK, eg); else n_pass++;
    n_chk++; if (ERR !== 1'b0 || GNT !== '0) $display("FAIL op_done err %b gnt %b want 0 000", ERR, GNT); else n_pass++;
    if (rd) begin
      n_chk++; if (RD_DATA !== rdat) $display("FAIL op_rdata got %h want %h", RD_DATA, rdat); else n_pass++;
    end
    SD_STATUS = 2'b01;
    if (!keep) REQ = REQ & ~eg;
  endtask

  task automatic test_reset;
    NSYSRESET = 1'b0;
    tick;
    tick;
    n_chk++; if ({GNT, ACK, ERR, CMD_IN, ERR_CNT, RD_DATA} !== '0) $display("FAIL reset_outs got %h want 0", {GNT, ACK, ERR, CMD_IN, ERR_CNT, RD_DATA}); else n_pass++;
    n_chk++; if ({A_IN_ROW, A_IN_BANK, A_IN_COL, D_IN} !== '0) $display("FAIL reset_addr got %h want 0", {A_IN_ROW, A_IN_BANK, A_IN_COL, D_IN}); else n_pass++;
    NSYSRESET = 1'b1;
    tick;
  endtask

  task automatic test_single_write;
    REQ_WR = 3'b001;
    REQ_ADDR[23:0] = 24'h123456;
    REQ_DATA[15:0] = 16'hBEEF;
    REQ = 3'b001;
    run_op(3'b001, 1'b0, 16'h0, 2, 1'b0, 3'b000, 1'b0);
    n_chk++; if (A_IN_ROW !== 13'h0246) $display("FAIL wr_row got %h want 0246", A_IN_ROW); else n_pass++;
    n_chk++; if (A_IN_BANK !== 2'b10) $display("FAIL wr_bank got %b want 10", A_IN_BANK); else n_pass++;
    n_chk++; if (A_IN_COL !== 9'h056) $display("FAIL wr_col got %h want 056", A_IN_COL); else n_pass++;
    n_chk++; if (D_IN !== 16'hBEEF) $display("FAIL wr_data got %h want BEEF", D_IN); else n_pass++;
    tick;
    n_chk++; if (ACK !== 3'b000) $display("FAIL wr_ack_pulse got %b want 000", ACK); else n_pass++;
  endtask

  task automatic test_read;
    REQ_WR = 3'b000;
    REQ_ADDR[47:24] = 24'h00ABCD;
    REQ = 3'b010;
    run_op(3'b010, 1'b1, 16'hA5A5, 1, 1'b1, 3'b000, 1'b0);
    tick;
    n_chk++; if (ACK !== 3'b000 || GNT !== 3'b000) $display("FAIL rd_after ack %b gnt %b want 000 000", ACK, GNT); else n_pass++;
    n_chk++; if (RD_DATA !== 16'hA5A5) $display("FAIL rd_hold got %h want A5A5", RD_DATA); else n_pass++;
  endtask

  task automatic test_round_robin;
    logic [N-1:0] seq [6];
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset;
    REQ_WR = 3'b111;
    REQ = 3'b111;
    for (int i = 0; i < 6; i++) run_op(seq[i], 1'b0, 16'h0, 3, 1'b0, 3'b000, 1'b1);
    REQ = '0;
    tick;
    n_chk++; if (GNT !== 3'b000) $display("FAIL rr_idle got %b want 000", GNT); else n_pass++;
  endtask

  task automatic test_timeout;
    do_reset;
    REQ_WR = 3'b100;
    REQ = 3'b100;
    tick;
    n_chk++; if (GNT !== 3'b100 || CMD_IN !== 2'b01) $display("FAIL to_issue gnt %b cmd %b want 100 01", GNT, CMD_IN); else n_pass++;
    SD_STATUS = 2'b00;
    repeat (15) tick;
    n_chk++; if (ACK !== 3'b000 || ERR !== 1'b0) $display("FAIL to_early ack %b err %b want 000 0", ACK, ERR); else n_pass++;
    tick;
    n_chk++; if (ACK !== 3'b100 || ERR !== 1'b1) $display("FAIL to_pulse ack %b err %b want 100 1", ACK, ERR); else n_pass++;
    n_chk++; if (CMD_IN !== 2'b00 || GNT !== 3'b000) $display("FAIL to_nop cmd %b gnt %b want 00 000", CMD_IN, GNT); else n_pass++;
    n_chk++; if (ERR_CNT !== 8'd1) $display("FAIL to_cnt1 got %0d want 1", ERR_CNT); else n_pass++;
    REQ = '0;
    SD_STATUS = 2'b01;
    tick;
    n_chk++; if (ERR !== 1'b0) $display("FAIL to_err_pulse got %b want 0", ERR); else n_pass++;
    REQ = 3'b100;
    tick;
    SD_STATUS = 2'b11;
    tick;
    n_chk++; if (ACK !== 3'b000 || CMD_IN !== 2'b01) $display("FAIL issue_done_ignored ack %b cmd %b want 000 01", ACK, CMD_IN); else n_pass++;
    SD_STATUS = 2'b01;
    repeat (14) tick;
    n_chk++; if (CMD_IN !== 2'b01) $display("FAIL issue_hold got %b want 01", CMD_IN); else n_pass++;
    tick;
    n_chk++; if (ACK !== 3'b100 || ERR !== 1'b1 || CMD_IN !== 2'b00) $display("FAIL issue_to ack %b err %b cmd %b want 100 1 00", ACK, ERR, CMD_IN); else n_pass++;
    n_chk++; if (ERR_CNT !== 8'd2) $display("FAIL to_cnt2 got %0d want 2", ERR_CNT); else n_pass++;
    REQ = '0;
    SD_STATUS = 2'b10;
    tick;
    n_chk++; if (ACK !== 3'b000 || GNT !== 3'b000) $display("FAIL idle_done_ignored ack %b gnt %b want 000 000", ACK, GNT); else n_pass++;
    SD_STATUS = 2'b01;
    REQ = 3'b100;
    repeat (17 * 256) tick;
    REQ = '0;
    repeat (20) tick;
    n_chk++; if (ERR_CNT !== 8'd255) $display("FAIL to_sat got %0d want 255", ERR_CNT); else n_pass++;
  endtask

  task automatic test_reset_mid_op;
    REQ_WR = 3'b001;
    REQ = 3'b001;
    tick;
    SD_STATUS = 2'b00;
    tick;
    #2 NSYSRESET = 1'b0;
    #1;
    n_chk++; if (GNT !== 3'b000 || CMD_IN !== 2'b00) $display("FAIL async_rst gnt %b cmd %b want 000 00", GNT, CMD_IN); else n_pass++;
    n_chk++; if (ERR_CNT !== 8'd0) $display("FAIL async_rst_cnt got %0d want 0", ERR_CNT); else n_pass++;
    REQ = '0;
    SD_STATUS = 2'b01;
    tick;
    NSYSRESET = 1'b1;
    tick;
    REQ_WR = 3'b000;
    REQ = 3'b010;
    run_op(3'b010, 1'b1, 16'h1234, 2, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic test_priority;
    logic [N-1:0] e1, e2;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    e1 = 3'b001;
    e2 = 3'b100;
`else
    e1 = 3'b100;
    e2 = 3'b001;
`endif
    do_reset;
    REQ_WR = 3'b111;
    REQ = 3'b110;
    run_op(3'b010, 1'b0, 16'h0, 2, 1'b0, 3'b001, 1'b0);
    run_op(e1, 1'b0, 16'h0, 2, 1'b0, 3'b000, 1'b0);
    run_op(e2, 1'b0, 16'h0, 2, 1'b0, 3'b000, 1'b0);
    tick;
    n_chk++; if (GNT !== 3'b000) $display("FAIL prio_idle got %b want 000", GNT); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_read;
    test_round_robin;
    test_timeout;
    test_reset_mid_op;
    test_priority;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
